// File: rtl/time_keeper.sv
// time_keeper: 1 Hz BCD hh:mm:ss clock with debounced auto-repeat hour/minute set buttons, sec_tick, blink and setting outputs
module time_keeper #(
  parameter int CLK_HZ = 25_000_000,
  parameter int DEBOUNCE_CYC = 250_000,
  parameter int REPEAT_DELAY_CYC = 12_500_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hour_button,
  input  logic       min_button,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       sec_tick,
  output logic       blink,
  output logic       setting
);
  localparam int PW = $clog2(CLK_HZ);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RW = $clog2(REPEAT_DELAY_CYC + 1);
  localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY_CYC);
  localparam logic [RW-1:0] R_RELOAD = RW'(REPEAT_DELAY_CYC - REPEAT_CYC);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    return v == top ? 8'h00 : v[3:0] == 4'h9 ? {v[7:4] + 4'h1, 4'h0} : {v[7:4], v[3:0] + 4'h1};
  endfunction

  logic [PW-1:0] presc, presc_n;
  logic [1:0] raw, db_n, step;
  logic sec_ev, min_carry, hour_carry;
  logic [7:0] sec_n, min_n, hour_a, hour_n;

  assign raw = {hour_button, min_button};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic s1, s2, db, dbn, accept;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt, rnext;
    assign accept = (s2 != db) && (dcnt == D_LAST);
    assign dbn = accept ? s2 : db;
    assign rnext = rcnt + 1'b1;
    assign db_n[g] = dbn;
    assign step[g] = (accept && s2) || (db && dbn && rnext == R_DELAY);
    always_ff @(posedge clk)
      if (rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        db <= 1'b0;
        dcnt <= '0;
        rcnt <= '0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        db <= dbn;
        dcnt <= (s2 != db && !accept) ? dcnt + 1'b1 : '0;
        rcnt <= (!db || !dbn) ? '0 : rnext == R_DELAY ? R_RELOAD : rnext;
      end
  end

  assign sec_ev = presc == P_LAST;
  assign presc_n = (step[0] || sec_ev) ? '0 : presc + 1'b1;
  assign min_carry = !step[0] && sec_ev && sec_bcd == 8'h59;
  assign hour_carry = min_carry && min_bcd == 8'h59;
  assign sec_n = step[0] ? 8'h00 : sec_ev ? bcd_inc(sec_bcd, 8'h59) : sec_bcd;
  assign min_n = (step[0] || min_carry) ? bcd_inc(min_bcd, 8'h59) : min_bcd;
  assign hour_a = hour_carry ? bcd_inc(hour_bcd, 8'h23) : hour_bcd;
  assign hour_n = step[1] ? bcd_inc(hour_a, 8'h23) : hour_a;

  always_ff @(posedge clk)
    if (rst) begin
      presc <= '0;
      hour_bcd <= 8'h00;
      min_bcd <= 8'h00;
      sec_bcd <= 8'h00;
      sec_tick <= 1'b0;
      blink <= 1'b1;
      setting <= 1'b0;
    end else begin
      presc <= presc_n;
      hour_bcd <= hour_n;
      min_bcd <= min_n;
      sec_bcd <= sec_n;
      sec_tick <= sec_ev;
      blink <= presc_n < P_HALF;
      setting <= |db_n;
    end
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed checks of time_keeper prescaler, rollover, debounce, auto-repeat and priority rules
module tb_time_keeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hour_button = 1'b0;
  logic min_button = 1'b0;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic sec_tick, blink, setting;
  int checks = 0;
  int errors = 0;

  time_keeper #(
    .CLK_HZ(10),
    .DEBOUNCE_CYC(4),
    .REPEAT_DELAY_CYC(20),
    .REPEAT_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hour_button(hour_button),
    .min_button(min_button),
    .hour_bcd(hour_bcd),
    .min_bcd(min_bcd),
    .sec_bcd(sec_bcd),
    .sec_tick(sec_tick),
    .blink(blink),
    .setting(setting)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic press(input bit h);
    if (h) hour_button = 1'b1;
    else min_button = 1'b1;
    repeat (8) tick();
    hour_button = 1'b0;
    min_button = 1'b0;
    repeat (8) tick();
  endtask

  task automatic preload_2359();
    int n;
    do_reset();
    repeat (23) press(1'b1);
    repeat (59) press(1'b0);
    n = 0;
    while (sec_bcd !== 8'h59 && n < 800) begin
      tick();
      n++;
    end
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h235959) begin
      errors++;
      $display("FAIL preload: got %h expected 235959", {hour_bcd, min_bcd, sec_bcd});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd, sec_tick, blink, setting} !== {24'h000000, 3'b010}) begin
      errors++;
      $display("FAIL reset_state: got %h %b%b%b expected 000000 010", {hour_bcd, min_bcd, sec_bcd}, sec_tick, blink, setting);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (blink !== ((k % 10) < 5) || sec_tick !== (k == 10) || sec_bcd !== (k == 10 ? 8'h01 : 8'h00)) begin
        errors++;
        $display("FAIL prescale cycle %0d: got blink=%b tick=%b sec=%h expected blink=%b tick=%b sec=%h",
                 k, blink, sec_tick, sec_bcd, (k % 10) < 5, k == 10, k == 10 ? 8'h01 : 8'h00);
      end
    end
  endtask

  task automatic test_rollover();
    int n;
    preload_2359();
    n = 0;
    do begin
      tick();
      n++;
    end while (sec_tick !== 1'b1 && n < 15);
    checks++;
    if (sec_tick !== 1'b1 || n != 10) begin
      errors++;
      $display("FAIL rollover_tick: got tick=%b after %0d cycles expected 1 after 10", sec_tick, n);
    end
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin
      errors++;
      $display("FAIL rollover_time: got %h expected 000000", {hour_bcd, min_bcd, sec_bcd});
    end
    tick();
    checks++;
    if (sec_tick !== 1'b0) begin
      errors++;
      $display("FAIL rollover_single_tick: got %b expected 0", sec_tick);
    end
  endtask

  task automatic test_debounce();
    hour_button = 1'b1;
    repeat (3) tick();
    hour_button = 1'b0;
    repeat (10) tick();
    checks++;
    if (hour_bcd !== 8'h00 || setting !== 1'b0) begin
      errors++;
      $display("FAIL glitch: got hour=%h setting=%b expected 00 0", hour_bcd, setting);
    end
    hour_button = 1'b1;
    repeat (5) tick();
    checks++;
    if (hour_bcd !== 8'h00 || setting !== 1'b0) begin
      errors++;
      $display("FAIL debounce_early: got hour=%h setting=%b expected 00 0", hour_bcd, setting);
    end
    tick();
    checks++;
    if (hour_bcd !== 8'h01 || setting !== 1'b1) begin
      errors++;
      $display("FAIL debounce_accept: got hour=%h setting=%b expected 01 1", hour_bcd, setting);
    end
    hour_button = 1'b0;
    repeat (8) tick();
    checks++;
    if (hour_bcd !== 8'h01 || setting !== 1'b0) begin
      errors++;
      $display("FAIL debounce_release: got hour=%h setting=%b expected 01 0", hour_bcd, setting);
    end
  endtask

  task automatic test_repeat();
    int offs [5] = '{20, 28, 36, 44, 52};
    int steps, last, m;
    logic [7:0] em, es;
    do_reset();
    repeat (56) press(1'b0);
    min_button = 1'b1;
    repeat (6) tick();
    checks++;
    if (min_bcd !== 8'h57 || sec_bcd !== 8'h00 || setting !== 1'b1) begin
      errors++;
      $display("FAIL repeat_first: got min=%h sec=%h setting=%b expected 57 00 1", min_bcd, sec_bcd, setting);
    end
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (k == 54) min_button = 1'b0;
      steps = 1;
      last = 0;
      foreach (offs[i]) if (offs[i] <= k) begin
        steps++;
        last = offs[i];
      end
      m = (56 + steps) % 60;
      em = 8'((m / 10) * 16 + m % 10);
      es = (k - last) >= 10 ? 8'h01 : 8'h00;
      checks++;
      if (min_bcd !== em || sec_bcd !== es || hour_bcd !== 8'h00 || setting !== (k < 60)) begin
        errors++;
        $display("FAIL repeat cycle %0d: got %h:%h:%h setting=%b expected 00:%h:%h setting=%b",
                 k, hour_bcd, min_bcd, sec_bcd, setting, em, es, k < 60);
      end
    end
  endtask

  task automatic test_simultaneous();
    int n;
    preload_2359();
    repeat (4) tick();
    hour_button = 1'b1;
    repeat (6) tick();
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h010000 || sec_tick !== 1'b1) begin
      errors++;
      $display("FAIL hour_step_carry: got %h tick=%b expected 010000 tick=1", {hour_bcd, min_bcd, sec_bcd}, sec_tick);
    end
    hour_button = 1'b0;
    n = 0;
    while (sec_bcd !== 8'h05 && n < 100) begin
      tick();
      n++;
    end
    repeat (4) tick();
    min_button = 1'b1;
    repeat (6) tick();
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h010100 || sec_tick !== 1'b1) begin
      errors++;
      $display("FAIL min_step_on_second: got %h tick=%b expected 010100 tick=1", {hour_bcd, min_bcd, sec_bcd}, sec_tick);
    end
    min_button = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid_repeat();
    do_reset();
    min_button = 1'b1;
    repeat (28) tick();
    checks++;
    if (min_bcd !== 8'h02 || setting !== 1'b1) begin
      errors++;
      $display("FAIL mid_repeat: got min=%h setting=%b expected 02 1", min_bcd, setting);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000 || setting !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_button: got %h setting=%b expected 000000 0", {hour_bcd, min_bcd, sec_bcd}, setting);
    end
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (min_bcd !== 8'h00 || setting !== 1'b0) begin
      errors++;
      $display("FAIL reaccept_early: got min=%h setting=%b expected 00 0", min_bcd, setting);
    end
    tick();
    checks++;
    if (min_bcd !== 8'h01 || setting !== 1'b1) begin
      errors++;
      $display("FAIL reaccept: got min=%h setting=%b expected 01 1", min_bcd, setting);
    end
    min_button = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_debounce();
    test_repeat();
    test_simultaneous();
    test_reset_mid_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day source for the VGA clock display. Divides the pixel clock down to a 1 Hz tick and keeps hours, minutes and seconds in BCD. Debounces the hour and minute set buttons and applies single-step and auto-repeat increments. Sits directly upstream of the `vga` renderer, which only draws the digits and colon it is given.

## Interface

Parameters:
- `CLK_HZ`, 25_000_000: clock cycles per second.
- `DEBOUNCE_CYC`, 250_000: consecutive stable cycles required to accept a button level change (10 ms).
- `REPEAT_DELAY_CYC`, 12_500_000: hold time from press to first auto-repeat (0.5 s).
- `REPEAT_CYC`, 5_000_000: auto-repeat period after the first repeat (0.2 s).

Ports:
- `clk` in 1: pixel clock; the block's only clock.
- `rst` in 1: synchronous reset, active-high.
- `hour_button` in 1: raw, asynchronous, active-high hour set button.
- `min_button` in 1: raw, asynchronous, active-high minute set button.
- `hour_bcd` out 8: hours 00–23, `[7:4]` tens, `[3:0]` units.
- `min_bcd` out 8: minutes 00–59.
- `sec_bcd` out 8: seconds 00–59.
- `sec_tick` out 1: one-cycle pulse on the cycle the seconds value advances.
- `blink` out 1: colon blink; high during the first half of each second.
- `setting` out 1: high while either debounced button is held.

## Operation

**Reset.** While `rst` is high at an edge:
- time 00:00:00, prescaler 0, both debounced states 0;
- repeat counters 0, `sec_tick` 0, `blink` 1, `setting` 0;
- synchronizer flops cleared.

**Prescaler.**
- Counter width is `$clog2(CLK_HZ)`; it counts 0..CLK_HZ-1 and then wraps to 0.
- The wrap cycle is the second event. On it, `sec_tick` is 1 for exactly one cycle and the seconds advance.
- `blink` = (prescaler < CLK_HZ/2).

**Time counting.** All digits are BCD and never hold a non-BCD value.
- Seconds: 59 → 00 carries into minutes.
- Minutes: 59 → 00 carries into hours.
- Hours: 23 → 00.

**Button path.** Each button is handled independently.
- Two-flop synchronizer, then a debounce counter.
- The counter counts while the synced level differs from the debounced state and clears when they match.
- When the count reaches DEBOUNCE_CYC, the debounced state takes the synced level and the counter clears.

**Step events.** A step is generated on:
- a debounced 0→1 edge (press);
- REPEAT_DELAY_CYC cycles after the press, while still held;
- every REPEAT_CYC cycles after that, while still held.

A debounced 1→0 edge (release) stops repeats immediately and clears that button's repeat counter.

**Step actions.**
- Minute step: minutes +1 mod 60, with no carry into hours. Seconds are set to 00 and the prescaler is set to 0.
- Hour step: hours +1 mod 24. Minutes and seconds are unaffected.

**Simultaneous events.**
- Minute step and second event in the same cycle: the minute step wins. Seconds become 00, and `sec_tick` is still pulsed.
- Hour step and hour carry in the same cycle: hours advance by 2 mod 24, so 23 → 01.
- Hour and minute steps in the same cycle: both apply.
- Reset asserted during debounce or repeat: all state is abandoned, and the button must be re-accepted after `rst` deasserts.

## Timing

- All outputs are registered and change only on rising `clk` edges.
- Raw button change to debounced change: 2 synchronizer cycles + DEBOUNCE_CYC cycles, exact for a glitch-free input.
- A glitch shorter than DEBOUNCE_CYC synced cycles produces no change.
- Step effect: the BCD outputs update on the same edge that registers the step (debounced edge or repeat count match).
- `sec_tick` is coincident with the `sec_bcd` update edge.
- `blink` changes on the edges where the prescaler becomes CLK_HZ/2 or wraps to 0.
- `setting` follows the OR of the debounced states with no extra latency.

## Test plan

Bench parameters: CLK_HZ=10, DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_CYC=8.

1. Reset, then run 10 cycles → `sec_tick` pulses once at cycle 10 and `sec_bcd`=0x01. `blink` is high for 5 cycles, then low for 5.
2. Preload time by stepping to 23:59:59, then run to the next second event → outputs 00:00:00 with a single `sec_tick`.
3. Raw hour glitch lasting 3 cycles → no change. Clean press held 6 cycles → `hour_bcd` +1 exactly 6 cycles after the raw edge, and `setting`=1 on that edge.
4. Hold the minute button for 60 cycles from acceptance → steps at +0, +20, +28, +36, +44, +52 (6 steps). After each step `sec_bcd`=0x00 and the prescaler is restarted. Minutes wrap 59→00 without touching the hours.
5. Hour step in the same cycle as a 23:59:59 second event → `hour_bcd`=0x01. Minute step on a second event → `sec_bcd`=0x00.
6. Assert `rst` mid-repeat while the button is held → time 00:00:00 and `setting`=0. After release of `rst`, the first step occurs DEBOUNCE_CYC+2 cycles later.
